alu_operand_fetch: RTL and testbench
====================================

// Module: alu_operand_fetch
// PURPOSE
// - Issue / operand-fetch stage directly upstream of the ALU.
// - Takes decoded ALU instructions and reads rs1/rs2 from the register file.
// - Resolves RAW/WAW hazards with a pending-write scoreboard and bypasses same-cycle writeback data.
// - Registers op + operands into a single pipeline slot that drives the ALU over valid/ready.
// PARAMETERS
// XLEN        32  data width of operands and register-file data
// NumInPort    2  operand count presented to the ALU (operand 1 may be immediate)
// NumRegs     32  architectural registers; index width RegW = $clog2(NumRegs)
// PORTS
// clk_i            in   1                   clock
// rst_ni           in   1                   reset, synchronous, active-low
// id_valid_i       in   1                   decoded instruction valid
// id_ready_o       out  1                   stage accepts instruction this cycle
// id_alu_op_i      in   alu_op_t            ALU operation
// id_rs1_i         in   RegW                source register 1
// id_rs2_i         in   RegW                source register 2 (ignored when id_use_imm_i)
// id_rd_i          in   RegW                destination register (0 = no write)
// id_use_imm_i     in   1                   operand 1 = id_imm_i instead of rs2
// id_imm_i         in   XLEN                sign-extended immediate
// rf_raddr_o       out  NumInPort x RegW    register-file read addresses (comb, = id_rs1_i/id_rs2_i)
// rf_rdata_i       in   NumInPort x XLEN    register-file read data, same cycle
// wb_valid_i       in   1                   writeback of an ALU result this cycle
// wb_rd_i          in   RegW                writeback destination
// wb_data_i        in   XLEN                writeback data
// flush_i          in   1                   kill the instruction held in the output slot
// ex_valid_o       out  1                   output slot holds a valid instruction
// ex_ready_i       in   1                   ALU consumes output slot
// ex_alu_op_o      out  alu_op_t            registered ALU op
// ex_operand_o     out  NumInPort x XLEN    registered operands, index 0 = rs1
// ex_rd_o          out  RegW                registered destination
// BEHAVIOUR
// - Reset (rst_ni=0 at clk edge):
//   - ex_valid_o=0; ex_alu_op_o=ALU_ADD; ex_operand_o=0; ex_rd_o=0.
//   - Scoreboard pending[NumRegs-1:0]=0.
// - Scoreboard:
//   - pending[0] is hard-wired 0.
//   - Issue with rd!=0 sets pending[rd].
//   - wb_valid_i clears pending[wb_rd_i].
//   - Issue and wb to the same rd in the same cycle: set wins.
// - Source readiness:
//   - srcN ready if reg==0, or !pending[reg], or (wb_valid_i && wb_rd_i==reg).
//   - rs2 ignored when id_use_imm_i.
// - Hazards:
//   - WAW: stall while pending[rd] and not cleared by this cycle's wb.
//   - Mux priority per operand: imm (operand 1 only) > wb bypass (reg!=0 && match) > rf_rdata_i.
// - Handshake:
//   - slot_free = !ex_valid_o || ex_ready_i.
//   - id_ready_o = slot_free && srcs ready && !WAW && !flush_i.
//   - Fire = id_valid_i && id_ready_o: slot loads op/operands/rd, ex_valid_o=1 next cycle.
//   - Output held stable while ex_valid_o && !ex_ready_i.
//   - Drain without fire: ex_valid_o=0.
//   - Latency: accept -> ex_valid_o is 1 cycle; back-to-back issue at full rate when hazard-free.
//   - Dependent back-to-back ops stall until the producer's wb cycle, then bypass in that cycle.
// - flush_i:
//   - ex_valid_o=0 next cycle; no accept that cycle.
//   - pending[ex_rd_o] cleared if the slot was valid (flush beats the hold).
//   - Instructions already inside the ALU still write back normally.
// - Reset mid-stall drops the slot and all pending bits; no partial state survives.
// STRUCTURE
// - alu_op_t (incl. ALU_ADD) comes from riscv_pkg.
// - Add to riscv_pkg: NUM_REGS, REG_W, and a packed alu_issue_t {op, operands, rd} for the slot.
// - One natural sub-module: alu_scoreboard (pending mask, set/clear/query ports).
// - Operand muxing and the pipeline slot stay in this module.
// TESTING
// - Reset, then issue ADD x3=x1+x2 with rf_rdata={5,7}, ex_ready_i=1
//   -> next cycle ex_valid_o=1, operands {5,7}, rd=3, pending[3]=1.
// - ADD x3 then SUB x4=x3-x1 back-to-back
//   -> id_ready_o=0 until wb_valid_i rd=3 data=12; that cycle SUB fires with operand0=12.
// - Issue with rd=0 and rs1=0
//   -> no pending bit set, operand from rf (0), never stalls.
// - ex_ready_i=0 for 3 cycles with slot valid
//   -> outputs stable, id_ready_o=0; ex_ready_i=1 with new fire -> new data next cycle, no bubble.
// - Slot valid rd=5, flush_i=1
//   -> ex_valid_o=0 next cycle, pending[5]=0, id_ready_o=0 during flush cycle.
// - Same-cycle issue rd=6 and wb rd=6 -> pending[6]=1 afterwards.
// - use_imm=1, imm=-1 -> operand1=32'hFFFF_FFFF regardless of rs2 pending.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: ALU operation encoding, register-file geometry
// and the packed issue record carried by the operand-fetch output slot.
package riscv_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned NUM_IN_PORT = 2;
    localparam int unsigned NUM_REGS    = 32;
    localparam int unsigned REG_W       = $clog2(NUM_REGS);

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_t;

    typedef struct packed {
        alu_op_t                              op;
        logic [NUM_IN_PORT-1:0][XLEN-1:0]     operands;
        logic [REG_W-1:0]                     rd;
    } alu_issue_t;

endpackage

// File: rtl/alu_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set on issue,
// cleared by writeback or by flushing the instruction that owns it.
module alu_scoreboard #(
    parameter int unsigned NumRegs = riscv_pkg::NUM_REGS,
    parameter int unsigned RegW    = $clog2(NumRegs)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                set_i,
    input  logic [RegW-1:0]     set_rd_i,
    input  logic                wb_clr_i,
    input  logic [RegW-1:0]     wb_clr_rd_i,
    input  logic                flush_clr_i,
    input  logic [RegW-1:0]     flush_clr_rd_i,
    output logic [NumRegs-1:0]  pending_o
);

    genvar gi;
    generate
        for (gi = 0; gi < NumRegs; gi++) begin : g_bit
            if (gi == 0) begin : g_zero
                assign pending_o[gi] = 1'b0;
            end else begin : g_reg
                logic w_set;
                logic w_clr;
                logic r_pending;

                assign w_set = set_i && (set_rd_i == RegW'(gi));
                assign w_clr = (wb_clr_i && (wb_clr_rd_i == RegW'(gi))) ||
                               (flush_clr_i && (flush_clr_rd_i == RegW'(gi)));

                // A new producer issued this cycle outranks a clear from an older one.
                always_ff @(posedge clk_i) begin
                    if (!rst_ni) begin
                        r_pending <= 1'b0;
                    end else if (w_set) begin
                        r_pending <= 1'b1;
                    end else if (w_clr) begin
                        r_pending <= 1'b0;
                    end
                end

                assign pending_o[gi] = r_pending;
            end
        end
    endgenerate

endmodule

// File: rtl/alu_operand_fetch.sv
// Issue / operand-fetch stage ahead of the ALU: hazard check against the
// scoreboard, writeback bypass, and a single valid/ready output slot.
module alu_operand_fetch
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN      = riscv_pkg::XLEN,
    parameter int unsigned NumInPort = riscv_pkg::NUM_IN_PORT,
    parameter int unsigned NumRegs   = riscv_pkg::NUM_REGS,
    localparam int unsigned RegW     = $clog2(NumRegs)
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               id_valid_i,
    output logic                               id_ready_o,
    input  alu_op_t                            id_alu_op_i,
    input  logic [RegW-1:0]                    id_rs1_i,
    input  logic [RegW-1:0]                    id_rs2_i,
    input  logic [RegW-1:0]                    id_rd_i,
    input  logic                               id_use_imm_i,
    input  logic [XLEN-1:0]                    id_imm_i,
    output logic [NumInPort-1:0][RegW-1:0]     rf_raddr_o,
    input  logic [NumInPort-1:0][XLEN-1:0]     rf_rdata_i,
    input  logic                               wb_valid_i,
    input  logic [RegW-1:0]                    wb_rd_i,
    input  logic [XLEN-1:0]                    wb_data_i,
    input  logic                               flush_i,
    output logic                               ex_valid_o,
    input  logic                               ex_ready_i,
    output alu_op_t                            ex_alu_op_o,
    output logic [NumInPort-1:0][XLEN-1:0]     ex_operand_o,
    output logic [RegW-1:0]                    ex_rd_o
);

    logic                          r_valid;
    alu_issue_t                    r_slot;
    alu_issue_t                    w_issue;
    logic [NumRegs-1:0]            w_pending;
    logic [NumInPort-1:0][RegW-1:0] w_rs;
    logic [NumInPort-1:0]          w_src_ready;
    logic                          w_slot_free;
    logic                          w_waw;
    logic                          w_fire;

    assign w_rs[0]    = id_rs1_i;
    assign w_rs[1]    = id_rs2_i;
    assign rf_raddr_o = w_rs;

    genvar gi;
    generate
        for (gi = 0; gi < NumInPort; gi++) begin : g_opnd
            logic w_imm_sel;
            logic w_bypass;

            // Only operand 1 can be replaced by the immediate.
            assign w_imm_sel = (gi == 1) && id_use_imm_i;
            assign w_bypass  = wb_valid_i && (w_rs[gi] != '0) && (wb_rd_i == w_rs[gi]);

            assign w_src_ready[gi] = w_imm_sel || (w_rs[gi] == '0) ||
                                     !w_pending[w_rs[gi]] || w_bypass;

            assign w_issue.operands[gi] = w_imm_sel ? id_imm_i   :
                                          w_bypass  ? wb_data_i  :
                                                      rf_rdata_i[gi];
        end
    endgenerate

    assign w_issue.op = id_alu_op_i;
    assign w_issue.rd = id_rd_i;

    assign w_waw       = w_pending[id_rd_i] && !(wb_valid_i && (wb_rd_i == id_rd_i));
    assign w_slot_free = !r_valid || ex_ready_i;
    assign id_ready_o  = w_slot_free && (&w_src_ready) && !w_waw && !flush_i;
    assign w_fire      = id_valid_i && id_ready_o;

    alu_scoreboard #(
        .NumRegs (NumRegs),
        .RegW    (RegW)
    ) u_scoreboard (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .set_i          (w_fire && (id_rd_i != '0)),
        .set_rd_i       (id_rd_i),
        .wb_clr_i       (wb_valid_i),
        .wb_clr_rd_i    (wb_rd_i),
        .flush_clr_i    (flush_i && r_valid),
        .flush_clr_rd_i (r_slot.rd),
        .pending_o      (w_pending)
    );

    // Flush outranks both a hold and a fire; it never coincides with a fire anyway.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_valid <= 1'b0;
            r_slot  <= '{op: ALU_ADD, operands: '0, rd: '0};
        end else if (flush_i) begin
            r_valid <= 1'b0;
        end else if (w_fire) begin
            r_valid <= 1'b1;
            r_slot  <= w_issue;
        end else if (w_slot_free) begin
            r_valid <= 1'b0;
        end
    end

    assign ex_valid_o   = r_valid;
    assign ex_alu_op_o  = r_slot.op;
    assign ex_operand_o = r_slot.operands;
    assign ex_rd_o      = r_slot.rd;

endmodule

// File: tb/tb_alu_operand_fetch.sv
// Directed bench for alu_operand_fetch: a cycle-by-cycle vector table plus
// hand-written backpressure, flush and reset-mid-stall sequences.
module tb_alu_operand_fetch;
    import riscv_pkg::*;

    logic                  clk;
    logic                  rst_n;
    logic                  id_valid;
    logic                  id_ready;
    alu_op_t               id_op;
    logic [4:0]            id_rs1, id_rs2, id_rd;
    logic                  id_use_imm;
    logic [31:0]           id_imm;
    logic [1:0][4:0]       rf_raddr;
    logic [1:0][31:0]      rf_rdata;
    logic                  wb_valid;
    logic [4:0]            wb_rd;
    logic [31:0]           wb_data;
    logic                  flush;
    logic                  ex_valid;
    logic                  ex_ready;
    alu_op_t               ex_op;
    logic [1:0][31:0]      ex_operand;
    logic [4:0]            ex_rd;

    int checks = 0;
    int errors = 0;

    alu_operand_fetch dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .id_valid_i   (id_valid),
        .id_ready_o   (id_ready),
        .id_alu_op_i  (id_op),
        .id_rs1_i     (id_rs1),
        .id_rs2_i     (id_rs2),
        .id_rd_i      (id_rd),
        .id_use_imm_i (id_use_imm),
        .id_imm_i     (id_imm),
        .rf_raddr_o   (rf_raddr),
        .rf_rdata_i   (rf_rdata),
        .wb_valid_i   (wb_valid),
        .wb_rd_i      (wb_rd),
        .wb_data_i    (wb_data),
        .flush_i      (flush),
        .ex_valid_o   (ex_valid),
        .ex_ready_i   (ex_ready),
        .ex_alu_op_o  (ex_op),
        .ex_operand_o (ex_operand),
        .ex_rd_o      (ex_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        alu_op_t     op;
        logic [4:0]  rs1, rs2, rd;
        logic        use_imm;
        logic [31:0] imm, rf0, rf1;
        logic        wbv;
        logic [4:0]  wbrd;
        logic [31:0] wbd;
        logic        e_rdy, e_vld;
        logic [31:0] e_op0, e_op1;
        logic [4:0]  e_rd;
        logic [31:0] e_pend;
    } vec_t;

    vec_t vec[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        id_valid = 1'b0; id_op = ALU_ADD; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        id_use_imm = 1'b0; id_imm = '0; rf_rdata = '0;
        wb_valid = 1'b0; wb_rd = '0; wb_data = '0; flush = 1'b0; ex_ready = 1'b1;
    endtask

    task automatic issue(input alu_op_t op, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [31:0] rf0, input logic [31:0] rf1);
        id_valid = 1'b1; id_op = op; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_use_imm = 1'b0; rf_rdata[0] = rf0; rf_rdata[1] = rf1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_valid"}, 32'(ex_valid), 32'd0);
        chk({tag, "_op"},    32'(ex_op), 32'(ALU_ADD));
        chk({tag, "_opnd0"}, ex_operand[0], 32'd0);
        chk({tag, "_opnd1"}, ex_operand[1], 32'd0);
        chk({tag, "_rd"},    32'(ex_rd), 32'd0);
        chk({tag, "_pend"},  dut.w_pending, 32'd0);
    endtask

    initial begin
        //        op       rs1 rs2 rd imm imm          rf0          rf1           wbv wbrd wbd     rdy vld op0          op1          rd  pend
        vec[0]  = '{ALU_ADD, 1, 2, 3, 0, 0,            5,           7,            0, 0, 0,        1, 1, 5,           7,           3, 32'h0000_0008};
        vec[1]  = '{ALU_SUB, 3, 1, 4, 0, 0,            99,          5,            0, 0, 0,        0, 0, 0,           0,           0, 32'h0000_0008};
        vec[2]  = '{ALU_SUB, 3, 1, 4, 0, 0,            99,          5,            0, 0, 0,        0, 0, 0,           0,           0, 32'h0000_0008};
        vec[3]  = '{ALU_SUB, 3, 1, 4, 0, 0,            99,          5,            1, 3, 12,       1, 1, 12,          5,           4, 32'h0000_0010};
        vec[4]  = '{ALU_ADD, 0, 0, 0, 0, 0,            0,           0,            1, 4, 7,        1, 1, 0,           0,           0, 32'h0000_0000};
        vec[5]  = '{ALU_AND, 1, 2, 7, 0, 0,            1,           2,            0, 0, 0,        1, 1, 1,           2,           7, 32'h0000_0080};
        vec[6]  = '{ALU_OR,  5, 6, 8, 0, 0,            3,           4,            0, 0, 0,        1, 1, 3,           4,           8, 32'h0000_0180};
        vec[7]  = '{ALU_XOR, 1, 2, 6, 0, 0,            10,          20,           1, 6, 55,       1, 1, 10,          20,          6, 32'h0000_01C0};
        vec[8]  = '{ALU_ADD, 1, 7, 9, 1, 32'hFFFF_FFFF, 3,          32'h1234,     0, 0, 0,        1, 1, 3,           32'hFFFF_FFFF, 9, 32'h0000_03C0};
        vec[9]  = '{ALU_ADD, 0, 0, 9, 0, 0,            0,           0,            0, 0, 0,        0, 0, 0,           0,           0, 32'h0000_03C0};
        vec[10] = '{ALU_SLT, 0, 0, 8, 0, 0,            0,           0,            1, 8, 1,        1, 1, 0,           0,           8, 32'h0000_03C0};

        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        check_reset_state("reset");
        rst_n = 1'b1;
        chk("reset_id_ready", 32'(id_ready), 32'd1);

        for (int i = 0; i < 11; i++) begin
            issue(vec[i].op, vec[i].rs1, vec[i].rs2, vec[i].rd, vec[i].rf0, vec[i].rf1);
            id_use_imm = vec[i].use_imm;
            id_imm     = vec[i].imm;
            wb_valid   = vec[i].wbv;
            wb_rd      = vec[i].wbrd;
            wb_data    = vec[i].wbd;
            #1;
            chk($sformatf("v%0d_raddr0", i), 32'(rf_raddr[0]), 32'(vec[i].rs1));
            chk($sformatf("v%0d_id_ready", i), 32'(id_ready), 32'(vec[i].e_rdy));
            tick();
            chk($sformatf("v%0d_ex_valid", i), 32'(ex_valid), 32'(vec[i].e_vld));
            if (vec[i].e_vld) begin
                chk($sformatf("v%0d_op", i), 32'(ex_op), 32'(vec[i].op));
                chk($sformatf("v%0d_opnd0", i), ex_operand[0], vec[i].e_op0);
                chk($sformatf("v%0d_opnd1", i), ex_operand[1], vec[i].e_op1);
                chk($sformatf("v%0d_rd", i), 32'(ex_rd), 32'(vec[i].e_rd));
            end
            chk($sformatf("v%0d_pend", i), dut.w_pending, vec[i].e_pend);
            $display("vector %0d: ready=%0b ex_valid=%0b opnd={%h,%h} rd=%0d pend=%h",
                     i, vec[i].e_rdy, ex_valid, ex_operand[0], ex_operand[1], ex_rd, dut.w_pending);
        end

        // Backpressure: slot holds rd=8 {0,0}; new instruction waits three cycles.
        wb_valid = 1'b0;
        ex_ready = 1'b0;
        issue(ALU_ADD, 1, 2, 10, 11, 22);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("hold%0d_id_ready", c), 32'(id_ready), 32'd0);
            tick();
            chk($sformatf("hold%0d_valid", c), 32'(ex_valid), 32'd1);
            chk($sformatf("hold%0d_rd", c), 32'(ex_rd), 32'd8);
            chk($sformatf("hold%0d_opnd0", c), ex_operand[0], 32'd0);
            $display("hold %0d: ex_valid=%0b rd=%0d", c, ex_valid, ex_rd);
        end
        ex_ready = 1'b1;
        #1;
        chk("release_id_ready", 32'(id_ready), 32'd1);
        tick();
        chk("release_valid", 32'(ex_valid), 32'd1);
        chk("release_opnd0", ex_operand[0], 32'd11);
        chk("release_opnd1", ex_operand[1], 32'd22);
        chk("release_rd", 32'(ex_rd), 32'd10);
        $display("release: ex_valid=%0b opnd={%h,%h} rd=%0d", ex_valid, ex_operand[0], ex_operand[1], ex_rd);

        // Flush the slot holding rd=10 while a hazard-free instruction is offered.
        ex_ready = 1'b0;
        flush = 1'b1;
        issue(ALU_ADD, 0, 0, 11, 0, 0);
        #1;
        chk("flush_id_ready", 32'(id_ready), 32'd0);
        tick();
        chk("flush_valid", 32'(ex_valid), 32'd0);
        chk("flush_pend10", 32'(dut.w_pending[10]), 32'd0);
        chk("flush_pend11", 32'(dut.w_pending[11]), 32'd0);
        $display("flush: ex_valid=%0b pend=%h", ex_valid, dut.w_pending);
        flush = 1'b0;

        // Refill the slot, stall it, then reset in the middle of the stall.
        issue(ALU_SUB, 1, 2, 12, 4, 3);
        tick();
        chk("prerst_valid", 32'(ex_valid), 32'd1);
        issue(ALU_ADD, 12, 0, 13, 0, 0);
        #1;
        chk("prerst_id_ready", 32'(id_ready), 32'd0);
        rst_n = 1'b0;
        tick();
        check_reset_state("midrst");
        $display("mid-stall reset: ex_valid=%0b pend=%h", ex_valid, dut.w_pending);
        rst_n = 1'b1;
        idle_inputs();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
